// File: rtl/pcm_pkg.sv
// Shared constants and FSM encoding for the multi-chip NMK112-style PCM bank arbiter.
package pcm_pkg;

   localparam int unsigned NMK_TABLE_LIMIT = 32'h400;
   localparam int unsigned NMK_BANKS       = 4;

   typedef enum logic {
      StIdle,
      StWait
   } arb_state_e;

endpackage

// File: rtl/nmk112_xlate.sv
// Combinational NMK112 address translation for one OKI chip: bank select plus
// optional phrase-table paging of the low 1 KiB.
module nmk112_xlate
   import pcm_pkg::*;
#(
   parameter int unsigned ABW   = 18,
   parameter int unsigned OBW   = 22,
   parameter int unsigned BANKW = 6
) (
   input  logic [NMK_BANKS-1:0][BANKW-1:0] banks,
   input  logic                            paged,
   input  logic [ABW-1:0]                  addr,
   output logic [OBW-1:0]                  rom_addr
);

   // Work on at least 18 bits so a[17:16] always exists.
   localparam int unsigned AW = (ABW > 18) ? ABW : 18;
   localparam int unsigned RW = BANKW + 16;

   logic [AW-1:0]    a;
   logic             in_table;
   logic [1:0]       b;
   logic [BANKW-1:0] bank;
   logic [RW-1:0]    raw;

   always_comb begin
      a        = AW'(addr);
      in_table = paged && (a < AW'(NMK_TABLE_LIMIT));
      b        = in_table ? a[9:8] : a[17:16];
      bank     = banks[b];
      raw      = in_table ? {bank, 8'h00, a[7:0]} : {bank, a[15:0]};
      rom_addr = OBW'(raw);
   end

endmodule

// File: rtl/pcm_bank_arbiter.sv
// Shares one SDRAM PCM port between NCHIP OKI ADPCM chips: per-chip NMK112 banks,
// one-entry per-chip cache and round-robin fetch arbitration.
module pcm_bank_arbiter
   import pcm_pkg::*;
#(
   parameter int unsigned       NCHIP = 2,
   parameter int unsigned       ABW   = 18,
   parameter int unsigned       OBW   = 22,
   parameter int unsigned       BANKW = 6,
   parameter logic [NCHIP-1:0]  PAGED = {NCHIP{1'b1}}
) (
   input  logic                 CLK,
   input  logic                 RESET_N,
   input  logic                 BANK_WE,
   input  logic [3:0]           BANK_SEL,
   input  logic [7:0]           BANK_DIN,
   input  logic [NCHIP*ABW-1:0] OKI_ADDR,
   output logic [NCHIP*8-1:0]   OKI_DATA,
   output logic [NCHIP-1:0]     OKI_OK,
   output logic                 ROM_CS,
   output logic [OBW-1:0]       ROM_ADDR,
   input  logic [7:0]           ROM_DATA,
   input  logic                 ROM_OK
);

   localparam int unsigned CW = (NCHIP > 1) ? $clog2(NCHIP) : 1;

   arb_state_e state_q, state_d;

   logic [NCHIP-1:0][NMK_BANKS-1:0][BANKW-1:0] bank_q;
   logic [NCHIP-1:0]                           valid_q;
   logic [NCHIP-1:0][ABW-1:0]                  caddr_q;
   logic [NCHIP-1:0][7:0]                      data_q;

   logic [CW-1:0]  ptr_q;
   logic [CW-1:0]  grant_q;
   logic [ABW-1:0] snap_q;
   logic           kill_q;
   logic           first_q;
   logic           rom_cs_q;
   logic [OBW-1:0] rom_addr_q;

   logic [NCHIP-1:0][ABW-1:0] oki_addr;
   logic [NCHIP-1:0][OBW-1:0] xl_addr;
   logic [NCHIP-1:0]          hit;
   logic [NCHIP-1:0]          pending;

   logic [1:0]     we_chip;
   logic           we_hit;
   logic [CW-1:0]  we_idx;
   logic [CW-1:0]  pick;
   logic           found;
   int unsigned    idx;
   logic           accept;
   logic           grant_go;

   for (genvar i = 0; i < NCHIP; i++) begin : g_chip
      assign oki_addr[i] = OKI_ADDR[i*ABW +: ABW];

      nmk112_xlate #(
         .ABW   (ABW),
         .OBW   (OBW),
         .BANKW (BANKW)
      ) u_xlate (
         .banks    (bank_q[i]),
         .paged    (PAGED[i]),
         .addr     (oki_addr[i]),
         .rom_addr (xl_addr[i])
      );

      assign hit[i]     = valid_q[i] && (caddr_q[i] == oki_addr[i]);
      assign pending[i] = !hit[i];
   end

   if (BANKW < 8) begin : g_din_unused
      logic unused_din;
      assign unused_din = ^BANK_DIN[7:BANKW];
   end

   // Writes naming a chip beyond NCHIP are dropped here.
   always_comb begin
      we_chip = BANK_SEL[3:2];
      we_hit  = BANK_WE && (32'(we_chip) < NCHIP);
      we_idx  = CW'(we_chip);
   end

   // First pending chip strictly after the pointer, wrapping.
   always_comb begin
      pick  = ptr_q;
      found = 1'b0;
      idx   = 0;
      for (int unsigned k = 1; k <= NCHIP; k++) begin
         idx = 32'(ptr_q) + k;
         if (idx >= NCHIP) begin
            idx = idx - NCHIP;
         end
         if (!found && pending[CW'(idx)]) begin
            pick  = CW'(idx);
            found = 1'b1;
         end
      end
   end

   // SDRAM ok may be stale in the first WAIT cycle, so it is only honoured afterwards.
   always_comb begin
      accept   = (state_q == StWait) && !first_q && ROM_OK;
      grant_go = (state_q == StIdle) && found;
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (grant_go) state_d = StWait;
         StWait:  if (accept)   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      ROM_CS   = rom_cs_q;
      ROM_ADDR = rom_addr_q;
      OKI_DATA = data_q;
      OKI_OK   = hit;
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         bank_q     <= '0;
         valid_q    <= '0;
         caddr_q    <= '0;
         data_q     <= '0;
         ptr_q      <= CW'(NCHIP - 1);
         grant_q    <= '0;
         snap_q     <= '0;
         kill_q     <= 1'b0;
         first_q    <= 1'b0;
         rom_cs_q   <= 1'b0;
         rom_addr_q <= '0;
      end else begin
         first_q <= 1'b0;

         if (grant_go) begin
            grant_q    <= pick;
            ptr_q      <= pick;
            snap_q     <= oki_addr[pick];
            rom_addr_q <= xl_addr[pick];
            rom_cs_q   <= 1'b1;
            first_q    <= 1'b1;
            // A bank change landing on the grant edge makes the fetched byte stale too.
            kill_q     <= we_hit && (we_idx == pick);
         end

         if ((state_q == StWait) && we_hit && (we_idx == grant_q)) begin
            kill_q <= 1'b1;
         end

         if (accept) begin
            data_q[grant_q]  <= ROM_DATA;
            caddr_q[grant_q] <= snap_q;
            valid_q[grant_q] <= !kill_q;
            rom_cs_q         <= 1'b0;
         end

         // Placed last so a same-cycle bank write beats a completing fetch.
         if (we_hit) begin
            bank_q[we_idx][BANK_SEL[1:0]] <= BANK_DIN[BANKW-1:0];
            valid_q[we_idx]               <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pcm_bank_arbiter.sv
// Directed bench for pcm_bank_arbiter: reset, paging, round-robin, stale ok,
// bank-write invalidation and asynchronous reset.
module tb_pcm_bank_arbiter;

   localparam int NCHIP = 2;
   localparam int ABW   = 18;
   localparam int OBW   = 22;

   logic                 clk      = 1'b0;
   logic                 rst_n    = 1'b0;
   logic                 bank_we  = 1'b0;
   logic [3:0]           bank_sel = '0;
   logic [7:0]           bank_din = '0;
   logic [NCHIP*ABW-1:0] oki_addr = '0;
   logic [7:0]           rom_data = '0;
   logic                 rom_ok   = 1'b0;

   logic [NCHIP*8-1:0] oki_data, np_oki_data;
   logic [NCHIP-1:0]   oki_ok, np_oki_ok;
   logic               rom_cs, np_rom_cs;
   logic [OBW-1:0]     rom_addr, np_rom_addr;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   pcm_bank_arbiter #(
      .NCHIP (NCHIP), .ABW (ABW), .OBW (OBW), .BANKW (6), .PAGED (2'b11)
   ) dut (
      .CLK (clk), .RESET_N (rst_n), .BANK_WE (bank_we), .BANK_SEL (bank_sel),
      .BANK_DIN (bank_din), .OKI_ADDR (oki_addr), .OKI_DATA (oki_data), .OKI_OK (oki_ok),
      .ROM_CS (rom_cs), .ROM_ADDR (rom_addr), .ROM_DATA (rom_data), .ROM_OK (rom_ok)
   );

   pcm_bank_arbiter #(
      .NCHIP (NCHIP), .ABW (ABW), .OBW (OBW), .BANKW (6), .PAGED (2'b00)
   ) dut_np (
      .CLK (clk), .RESET_N (rst_n), .BANK_WE (bank_we), .BANK_SEL (bank_sel),
      .BANK_DIN (bank_din), .OKI_ADDR (oki_addr), .OKI_DATA (np_oki_data),
      .OKI_OK (np_oki_ok), .ROM_CS (np_rom_cs), .ROM_ADDR (np_rom_addr),
      .ROM_DATA (rom_data), .ROM_OK (rom_ok)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n   = 1'b0;
      rom_ok  = 1'b0;
      bank_we = 1'b0;
      tick;
      tick;
   endtask

   task automatic wait_cs(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick;
         if (rom_cs === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Serves one fetch: idle first WAIT cycle, then ROM_OK with data d.
   task automatic fetch(input logic [7:0] d, output logic [OBW-1:0] a,
                        output logic [OBW-1:0] na, output bit ok);
      wait_cs(ok);
      a  = rom_addr;
      na = np_rom_addr;
      if (ok) begin
         rom_ok = 1'b0;
         tick;
         rom_ok   = 1'b1;
         rom_data = d;
         tick;
         rom_ok = 1'b0;
      end
   endtask

   task automatic test_reset;
      rst_n    = 1'b0;
      oki_addr = {18'h04000, 18'h12345};
      tick;
      tick;
      vectors++; if (rom_cs !== 1'b0) begin errors++; $display("FAIL rst_cs got %b want 0", rom_cs); end
      vectors++; if (rom_addr !== 22'h0) begin errors++; $display("FAIL rst_addr got %h want 0", rom_addr); end
      vectors++; if (oki_ok !== 2'b00) begin errors++; $display("FAIL rst_ok got %b want 00", oki_ok); end
      vectors++; if (oki_data !== 16'h0) begin errors++; $display("FAIL rst_data got %h want 0", oki_data); end
      rst_n = 1'b1;
      tick;
      vectors++; if (rom_cs !== 1'b1) begin errors++; $display("FAIL first_cs got %b want 1", rom_cs); end
      vectors++; if (rom_addr !== 22'h002345) begin errors++; $display("FAIL first_addr got %h want 002345", rom_addr); end
      vectors++; if (np_rom_addr !== 22'h002345) begin errors++; $display("FAIL first_np_addr got %h want 002345", np_rom_addr); end
      rom_ok = 1'b0;
      tick;
      vectors++; if (rom_cs !== 1'b1) begin errors++; $display("FAIL wait_cs got %b want 1", rom_cs); end
      vectors++; if (oki_ok[0] !== 1'b0) begin errors++; $display("FAIL wait_ok got %b want 0", oki_ok[0]); end
      rom_ok   = 1'b1;
      rom_data = 8'hA5;
      tick;
      rom_ok = 1'b0;
      vectors++; if (oki_data[7:0] !== 8'hA5) begin errors++; $display("FAIL first_data got %h want a5", oki_data[7:0]); end
      vectors++; if (oki_ok[0] !== 1'b1) begin errors++; $display("FAIL first_ok got %b want 1", oki_ok[0]); end
      vectors++; if (rom_cs !== 1'b0) begin errors++; $display("FAIL cs_drop got %b want 0", rom_cs); end
   endtask

   task automatic test_paging;
      logic [OBW-1:0] a, na;
      bit ok;
      do_reset;
      oki_addr = {18'h04100, 18'h00234};
      rst_n    = 1'b1;
      fetch(8'h10, a, na, ok);
      vectors++; if (!ok) begin errors++; $display("FAIL pg_to1 got timeout want rom_cs"); end
      vectors++; if (a !== 22'h000034) begin errors++; $display("FAIL pg_addr0 got %h want 000034", a); end
      vectors++; if (na !== 22'h000234) begin errors++; $display("FAIL np_addr0 got %h want 000234", na); end
      fetch(8'h20, a, na, ok);
      vectors++; if (a !== 22'h004100) begin errors++; $display("FAIL pg_chip1 got %h want 004100", a); end
      bank_we = 1'b1; bank_sel = 4'b0010; bank_din = 8'h07;
      tick;
      bank_we = 1'b0;
      fetch(8'h30, a, na, ok);
      vectors++; if (a !== 22'h070034) begin errors++; $display("FAIL pg_bank2 got %h want 070034", a); end
      vectors++; if (na !== 22'h000234) begin errors++; $display("FAIL np_bank2 got %h want 000234", na); end
      bank_we = 1'b1; bank_sel = 4'b0000; bank_din = 8'hC5;
      tick;
      bank_we = 1'b0;
      fetch(8'h40, a, na, ok);
      vectors++; if (a !== 22'h070034) begin errors++; $display("FAIL pg_bank0 got %h want 070034", a); end
      vectors++; if (na !== 22'h050234) begin errors++; $display("FAIL np_bank0 got %h want 050234", na); end
      // Chip index 2 does not exist with two chips.
      bank_we = 1'b1; bank_sel = 4'b1000; bank_din = 8'h3F;
      tick;
      bank_we = 1'b0;
      tick;
      tick;
      vectors++; if (rom_cs !== 1'b0) begin errors++; $display("FAIL bad_chip_cs got %b want 0", rom_cs); end
      vectors++; if (oki_ok !== 2'b11) begin errors++; $display("FAIL bad_chip_ok got %b want 11", oki_ok); end
   endtask

   task automatic test_contention;
      do_reset;
      oki_addr = {18'h08100, 18'h01100};
      rst_n    = 1'b1;
      rom_ok   = 1'b1;
      rom_data = 8'h55;
      for (int i = 0; i < 12; i++) begin
         oki_addr = {18'h08100 + 18'(i), 18'h01100 + 18'(i)};
         tick;
         vectors++;
         if (rom_cs !== ((i % 3) != 2)) begin
            errors++; $display("FAIL rr_cs[%0d] got %b want %b", i, rom_cs, (i % 3) != 2);
         end
         if ((i % 3) == 0) begin
            vectors++;
            if (rom_addr[15] !== 1'((i / 3) % 2)) begin
               errors++; $display("FAIL rr_grant[%0d] got chip %b want %0d", i, rom_addr[15], (i / 3) % 2);
            end
         end
      end
      rom_ok = 1'b0;
   endtask

   task automatic test_stale_ok;
      do_reset;
      oki_addr = {18'h04000, 18'h00500};
      rom_ok   = 1'b1;
      rom_data = 8'h3C;
      rst_n    = 1'b1;
      tick;
      vectors++; if (rom_cs !== 1'b1) begin errors++; $display("FAIL stale_cs got %b want 1", rom_cs); end
      tick;
      vectors++; if (oki_ok[0] !== 1'b0) begin errors++; $display("FAIL stale_ok got %b want 0", oki_ok[0]); end
      vectors++; if (oki_data[7:0] !== 8'h00) begin errors++; $display("FAIL stale_data got %h want 00", oki_data[7:0]); end
      rom_data = 8'h5A;
      tick;
      rom_ok = 1'b0;
      vectors++; if (oki_data[7:0] !== 8'h5A) begin errors++; $display("FAIL second_data got %h want 5a", oki_data[7:0]); end
      vectors++; if (oki_ok[0] !== 1'b1) begin errors++; $display("FAIL second_ok got %b want 1", oki_ok[0]); end
      oki_addr[17:0] = 18'h00501;
      #1;
      vectors++; if (oki_ok[0] !== 1'b0) begin errors++; $display("FAIL addr_change_ok got %b want 0", oki_ok[0]); end
   endtask

   task automatic test_bank_kill;
      logic [OBW-1:0] a, na;
      bit ok;
      do_reset;
      oki_addr = {18'h04200, 18'h10005};
      rst_n    = 1'b1;
      tick;
      vectors++; if (rom_addr !== 22'h000005) begin errors++; $display("FAIL kill_addr got %h want 000005", rom_addr); end
      bank_we = 1'b1; bank_sel = 4'b0001; bank_din = 8'h09; rom_ok = 1'b0;
      tick;
      bank_we = 1'b0; rom_ok = 1'b1; rom_data = 8'h77;
      tick;
      rom_ok = 1'b0;
      vectors++; if (oki_ok[0] !== 1'b0) begin errors++; $display("FAIL kill_ok got %b want 0", oki_ok[0]); end
      vectors++; if (oki_data[7:0] !== 8'h77) begin errors++; $display("FAIL kill_data got %h want 77", oki_data[7:0]); end
      vectors++; if (rom_cs !== 1'b0) begin errors++; $display("FAIL kill_cs got %b want 0", rom_cs); end
      fetch(8'h11, a, na, ok);
      vectors++; if (!ok) begin errors++; $display("FAIL kill_to got timeout want rom_cs"); end
      vectors++; if (a !== 22'h004200) begin errors++; $display("FAIL kill_rr got %h want 004200", a); end
      vectors++; if (oki_ok !== 2'b10) begin errors++; $display("FAIL kill_ok2 got %b want 10", oki_ok); end
      tick;
      vectors++; if (rom_cs !== 1'b1) begin errors++; $display("FAIL refetch_cs got %b want 1", rom_cs); end
      vectors++; if (rom_addr !== 22'h090005) begin errors++; $display("FAIL refetch_addr got %h want 090005", rom_addr); end
      rom_ok = 1'b0;
      tick;
      rom_ok = 1'b1; rom_data = 8'h22; bank_we = 1'b1; bank_sel = 4'b0100; bank_din = 8'h01;
      tick;
      rom_ok = 1'b0; bank_we = 1'b0;
      vectors++; if (oki_ok !== 2'b01) begin errors++; $display("FAIL other_chip_ok got %b want 01", oki_ok); end
      vectors++; if (oki_data[7:0] !== 8'h22) begin errors++; $display("FAIL other_chip_data got %h want 22", oki_data[7:0]); end
      tick;
      vectors++; if (rom_addr !== 22'h014200) begin errors++; $display("FAIL chip1_addr got %h want 014200", rom_addr); end
      rom_ok = 1'b0;
      tick;
      rom_ok = 1'b1; rom_data = 8'h33; bank_we = 1'b1; bank_sel = 4'b0110; bank_din = 8'h02;
      tick;
      rom_ok = 1'b0; bank_we = 1'b0;
      vectors++; if (oki_ok !== 2'b01) begin errors++; $display("FAIL same_cycle_ok got %b want 01", oki_ok); end
      vectors++; if (oki_data[15:8] !== 8'h33) begin errors++; $display("FAIL same_cycle_data got %h want 33", oki_data[15:8]); end
   endtask

   task automatic test_async_reset;
      logic [OBW-1:0] a, na;
      bit ok;
      do_reset;
      oki_addr = {18'h04300, 18'h02000};
      rst_n    = 1'b1;
      fetch(8'h44, a, na, ok);
      vectors++; if (a !== 22'h002000) begin errors++; $display("FAIL ar_addr0 got %h want 002000", a); end
      tick;
      vectors++; if (rom_addr !== 22'h004300) begin errors++; $display("FAIL ar_addr1 got %h want 004300", rom_addr); end
      rom_ok = 1'b1; rom_data = 8'h99;
      tick;
      #2;
      rst_n = 1'b0;
      #1;
      vectors++; if (rom_cs !== 1'b0) begin errors++; $display("FAIL ar_cs got %b want 0", rom_cs); end
      vectors++; if (oki_ok !== 2'b00) begin errors++; $display("FAIL ar_ok got %b want 00", oki_ok); end
      vectors++; if (rom_addr !== 22'h0) begin errors++; $display("FAIL ar_rom_addr got %h want 0", rom_addr); end
      rom_ok = 1'b0;
      tick;
      rst_n = 1'b1;
      tick;
      vectors++; if (rom_cs !== 1'b1) begin errors++; $display("FAIL ar_restart_cs got %b want 1", rom_cs); end
      vectors++; if (rom_addr !== 22'h002000) begin errors++; $display("FAIL ar_restart_addr got %h want 002000", rom_addr); end
      vectors++; if (oki_data !== 16'h0) begin errors++; $display("FAIL ar_data got %h want 0", oki_data); end
   endtask

   initial begin
      test_reset;
      test_paging;
      test_contention;
      test_stale_ok;
      test_bank_kill;
      test_async_reset;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
